// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
    localparam int NREQ  = 2;
    localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core (req 0) and the loader (req 1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int LATENCY = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW-1:0]   wdata1,
    output logic [NREQ-1:0] done,
    output logic [DW-1:0]   rdata,
    output logic            busy,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             win;
`ifdef DMEM_ARB_RR_EN
    logic             last_q, last_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
        win     = (&req) ? ~last_q : req[1];
`else
        win     = ~req[0];
`endif
        case (state_q)
            ARB_IDLE: if (|req) begin
                state_d = ARB_ISSUE;
                gnt_d   = win;
                we_d    = we[win];
                addr_d  = win ? addr1 : addr0;
                wdata_d = win ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
                last_d  = win;
`endif
            end
            ARB_ISSUE: begin
                state_d = we_q ? ARB_DONE : ARB_WAIT;
                cnt_d   = LAT_M1;
            end
            ARB_WAIT: if (cnt_q == '0) begin
                rdata_d = mem_rdata;
                state_d = ARB_DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign done      = (state_q == ARB_DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = state_q != ARB_IDLE;
    assign mem_en    = state_q == ARB_ISSUE;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
endmodule
